// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine-timer peripheral: register word indices,
// CTRL bit positions and the CTRL register layout.
package mtimer_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_PRESC    = 3'd1;
  localparam logic [2:0] ADDR_MTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd4;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;
  localparam logic [2:0] ADDR_PERIOD   = 3'd7;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;
  localparam int CTRL_AR = 2;

  typedef struct packed {
    logic ar;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] ctrl_word(ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN] = c.en;
    w[CTRL_IE] = c.ie;
    w[CTRL_AR] = c.ar;
    return w;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Programmable prescaler: counts enabled cycles and emits a one-cycle tick
// every presc+1 cycles; a clear restarts the count.
module mtimer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clear || tick) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mtimer_irq.sv
// Machine-timer peripheral: 64-bit mtime behind a prescaler, 64-bit mtimecmp
// and a registered tm_interrupt level. Define MTIMER_AUTORELOAD_EN for periodic autoreload.
module mtimer_irq
  import mtimer_pkg::*;
#(
  parameter int          PRESC_W = 16,
  parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        tm_interrupt
);

  ctrl_t              ctrl;
  logic [PRESC_W-1:0] presc;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               guard;
  logic [31:0]        hi_shadow;
  logic [31:0]        rd_word;
  logic [2:0]         word;
  logic               wr_en;
  logic               rd_en;
  logic               cmp_wr;
  logic               match;
  logic               tick;
  logic               unused_addr_bits;

  assign word             = addr[4:2];
  assign wr_en            = req && we;
  assign rd_en            = req && !we;
  assign cmp_wr           = wr_en && ((word == ADDR_CMP_LO) || (word == ADDR_CMP_HI));
  assign match            = (mtime >= mtimecmp);
  assign unused_addr_bits = ^addr[1:0];

`ifdef MTIMER_AUTORELOAD_EN
  logic [31:0] period;
  logic        reload;
  // A software compare write in the same cycle takes priority over the reload.
  assign reload = ctrl.ar && match && !guard && (period != '0) && !cmp_wr;
`endif

  mtimer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.en),
    .clear (wr_en && (word == ADDR_PRESC)),
    .presc (presc),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl  <= '0;
      presc <= '0;
`ifdef MTIMER_AUTORELOAD_EN
      period <= '0;
`endif
    end else if (wr_en) begin
      if (word == ADDR_CTRL) begin
        ctrl.en <= wdata[CTRL_EN];
        ctrl.ie <= wdata[CTRL_IE];
`ifdef MTIMER_AUTORELOAD_EN
        ctrl.ar <= wdata[CTRL_AR];
`else
        ctrl.ar <= 1'b0;
`endif
      end
      if (word == ADDR_PRESC) presc <= wdata[PRESC_W-1:0];
`ifdef MTIMER_AUTORELOAD_EN
      if (word == ADDR_PERIOD) period <= wdata;
`endif
    end
  end

  // Software writes to either half of mtime override the tick for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_en && (word == ADDR_MTIME_LO)) begin
      mtime[31:0] <= wdata;
    end else if (wr_en && (word == ADDR_MTIME_HI)) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= RST_CMP;
      guard    <= 1'b0;
    end else if (wr_en && (word == ADDR_CMP_LO)) begin
      mtimecmp[31:0] <= wdata;
      guard          <= 1'b1;
    end else if (wr_en && (word == ADDR_CMP_HI)) begin
      mtimecmp[63:32] <= wdata;
      guard           <= 1'b0;
`ifdef MTIMER_AUTORELOAD_EN
    end else if (reload) begin
      mtimecmp <= mtimecmp + {32'h0, period};
`endif
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      ADDR_CTRL:     rd_word = ctrl_word(ctrl);
      ADDR_PRESC:    rd_word[PRESC_W-1:0] = presc;
      ADDR_MTIME_LO: rd_word = mtime[31:0];
      ADDR_MTIME_HI: rd_word = hi_shadow;
      ADDR_CMP_LO:   rd_word = mtimecmp[31:0];
      ADDR_CMP_HI:   rd_word = mtimecmp[63:32];
      ADDR_STATUS:   rd_word = {30'b0, guard, match};
`ifdef MTIMER_AUTORELOAD_EN
      ADDR_PERIOD:   rd_word = period;
`endif
      default:       rd_word = '0;
    endcase
  end

  // Reading MTIME_LO latches the upper half so a following HI read is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      hi_shadow <= '0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= rd_word;
        if (word == ADDR_MTIME_LO) hi_shadow <= mtime[63:32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tm_interrupt <= 1'b0;
    end else begin
      tm_interrupt <= ctrl.ie && !guard && match;
    end
  end

endmodule
